// File: rtl/asa_cfg_reg_bank.sv
// asa_cfg_reg_bank: PIO register bank with shadow/commit configuration words and sticky W1C status.
// Build option: define ASA_REG_STAT_EN to implement the status words, IRQ mask and stat_irq.
`ifndef PIO_NBITS
`define PIO_NBITS 32
`endif

module asa_cfg_reg_bank #(
    parameter int NUM_CFG   = 4,
    parameter int CFG_NBITS = 16,
    parameter int NUM_STAT  = 2,
    parameter int ADDR_LSB  = 2,
    parameter logic [NUM_CFG*CFG_NBITS-1:0] CFG_RST = '0
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            clk_div,
    input  logic                            reg_bs,
    input  logic                            reg_rd,
    input  logic                            reg_wr,
    input  logic [`PIO_NBITS-1:0]           reg_addr,
    input  logic [`PIO_NBITS-1:0]           reg_din,
    output logic                            pio_ack,
    output logic                            pio_rvalid,
    output logic [`PIO_NBITS-1:0]           pio_rdata,
    output logic [NUM_CFG*CFG_NBITS-1:0]    cfg_out,
    output logic                            cfg_update,
    input  logic [NUM_STAT*CFG_NBITS-1:0]   stat_event,
    output logic                            stat_irq
);

    localparam int PIO_W = `PIO_NBITS;
    localparam logic [3:0] IDX_COMMIT = 4'(NUM_CFG);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ACK
    } state_t;

    state_t                         state_reg;
    logic                           rd_flag_reg;
    logic                           mapped_reg;
    logic [CFG_NBITS-1:0]           rdata_lat_reg;
    logic                           commit_reg;
    logic                           cfg_update_reg;

    logic [NUM_CFG*CFG_NBITS-1:0]   shadow_flat;
    logic [NUM_CFG*CFG_NBITS-1:0]   active_flat;

    logic [3:0]                     req_idx;
    logic                           req_accept;
    logic                           wr_accept;
    logic [CFG_NBITS-1:0]           wr_data;
    logic [CFG_NBITS-1:0]           rd_word_next;
    logic                           rd_mapped_next;

    // Only the index field and the low word of write data are decoded.
    logic unused_bus;
    assign unused_bus = ^{reg_din, reg_addr};

    assign req_idx    = reg_addr[ADDR_LSB+3:ADDR_LSB];
    assign req_accept = (state_reg == ST_IDLE) && reg_bs && (reg_rd || reg_wr);
    assign wr_accept  = req_accept && reg_wr;
    assign wr_data    = reg_din[CFG_NBITS-1:0];

`ifdef ASA_REG_STAT_EN
    localparam logic [3:0] IDX_STAT = 4'(NUM_CFG + 1);
    localparam logic [3:0] IDX_MASK = 4'(NUM_CFG + NUM_STAT + 1);

    logic [NUM_STAT*CFG_NBITS-1:0]  status_flat;
    logic [NUM_STAT-1:0]            mask_reg;
    logic [NUM_STAT-1:0]            irq_terms;
`endif

    // Read data is captured in the request cycle, so it reflects pre-write register state.
    always_comb begin
        rd_word_next   = '0;
        rd_mapped_next = 1'b0;
        for (int i = 0; i < NUM_CFG; i++) begin
            if (req_idx == 4'(i)) begin
                rd_mapped_next = 1'b1;
                rd_word_next   = shadow_flat[i*CFG_NBITS +: CFG_NBITS];
            end
        end
        if (req_idx == IDX_COMMIT) begin
            rd_mapped_next = 1'b1;
        end
`ifdef ASA_REG_STAT_EN
        for (int j = 0; j < NUM_STAT; j++) begin
            if (req_idx == IDX_STAT + 4'(j)) begin
                rd_mapped_next = 1'b1;
                rd_word_next   = status_flat[j*CFG_NBITS +: CFG_NBITS];
            end
        end
        if (req_idx == IDX_MASK) begin
            rd_mapped_next = 1'b1;
            rd_word_next   = CFG_NBITS'(mask_reg);
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            rd_flag_reg   <= 1'b0;
            mapped_reg    <= 1'b0;
            rdata_lat_reg <= '0;
            pio_ack       <= 1'b0;
            pio_rvalid    <= 1'b0;
            pio_rdata     <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (req_accept) begin
                        rd_flag_reg   <= reg_rd;
                        mapped_reg    <= rd_mapped_next;
                        rdata_lat_reg <= rd_word_next;
                        state_reg     <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (clk_div) begin
                        pio_ack    <= 1'b1;
                        pio_rvalid <= rd_flag_reg && mapped_reg;
                        pio_rdata  <= (rd_flag_reg && mapped_reg) ? PIO_W'(rdata_lat_reg) : '0;
                        state_reg  <= ST_ACK;
                    end
                end
                ST_ACK: begin
                    if (clk_div) begin
                        pio_ack    <= 1'b0;
                        pio_rvalid <= 1'b0;
                        pio_rdata  <= '0;
                        state_reg  <= ST_IDLE;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    // Commit is registered once so every shadow write of cycle T is visible before the transfer.
    always_ff @(posedge clk) begin
        if (rst) begin
            commit_reg     <= 1'b0;
            cfg_update_reg <= 1'b0;
        end else begin
            commit_reg     <= wr_accept && (req_idx == IDX_COMMIT) && reg_din[0];
            cfg_update_reg <= commit_reg;
        end
    end

    assign cfg_update = cfg_update_reg;
    assign cfg_out    = active_flat;

    for (genvar gi = 0; gi < NUM_CFG; gi++) begin : g_cfg
        logic [CFG_NBITS-1:0] shadow_reg;
        logic [CFG_NBITS-1:0] active_reg;

        always_ff @(posedge clk) begin
            if (rst) begin
                shadow_reg <= CFG_RST[gi*CFG_NBITS +: CFG_NBITS];
                active_reg <= CFG_RST[gi*CFG_NBITS +: CFG_NBITS];
            end else begin
                if (wr_accept && (req_idx == 4'(gi))) begin
                    shadow_reg <= wr_data;
                end
                if (commit_reg) begin
                    active_reg <= shadow_reg;
                end
            end
        end

        assign shadow_flat[gi*CFG_NBITS +: CFG_NBITS] = shadow_reg;
        assign active_flat[gi*CFG_NBITS +: CFG_NBITS] = active_reg;
    end

`ifdef ASA_REG_STAT_EN
    for (genvar gi = 0; gi < NUM_STAT; gi++) begin : g_stat
        logic [CFG_NBITS-1:0] status_reg;
        logic [CFG_NBITS-1:0] w1c_mask;

        assign w1c_mask = (wr_accept && (req_idx == IDX_STAT + 4'(gi))) ? wr_data : '0;

        // Event OR is applied after the clear, so a same-cycle set wins.
        always_ff @(posedge clk) begin
            if (rst) begin
                status_reg <= '0;
            end else begin
                status_reg <= (status_reg & ~w1c_mask) | stat_event[gi*CFG_NBITS +: CFG_NBITS];
            end
        end

        assign status_flat[gi*CFG_NBITS +: CFG_NBITS] = status_reg;
        assign irq_terms[gi] = mask_reg[gi] && (|status_reg);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mask_reg <= '0;
            stat_irq <= 1'b0;
        end else begin
            if (wr_accept && (req_idx == IDX_MASK)) begin
                mask_reg <= reg_din[NUM_STAT-1:0];
            end
            stat_irq <= |irq_terms;
        end
    end
`else
    logic unused_stat;
    assign unused_stat = ^stat_event;
    assign stat_irq    = 1'b0;
`endif

endmodule

// File: tb/tb_asa_cfg_reg_bank.sv
// Self-checking bench for asa_cfg_reg_bank: directed scenarios plus randomized PIO traffic
// compared against an array-based register model.
`timescale 1ns/1ps

module tb_asa_cfg_reg_bank;

    localparam int NUM_CFG   = 4;
    localparam int CFG_NBITS = 16;
    localparam int NUM_STAT  = 2;
    localparam int ADDR_LSB  = 2;
    localparam logic [63:0] CFG_RST = 64'h0000_0F0F_00A5_0000;
`ifdef ASA_REG_STAT_EN
    localparam bit STAT_EN = 1'b1;
`else
    localparam bit STAT_EN = 1'b0;
`endif
    localparam int IDX_COMMIT = NUM_CFG;
    localparam int IDX_STAT   = NUM_CFG + 1;
    localparam int IDX_MASK   = NUM_CFG + NUM_STAT + 1;

    logic        clk = 1'b0;
    logic        rst;
    logic        clk_div;
    logic        reg_bs;
    logic        reg_rd;
    logic        reg_wr;
    logic [31:0] reg_addr;
    logic [31:0] reg_din;
    logic        pio_ack;
    logic        pio_rvalid;
    logic [31:0] pio_rdata;
    logic [63:0] cfg_out;
    logic        cfg_update;
    logic [31:0] stat_event;
    logic        stat_irq;

    int n_checks = 0;
    int n_errors = 0;
    int n_tx     = 0;
    int div_n    = 1;
    int div_cnt  = 0;

    logic [15:0]         m_shadow [NUM_CFG];
    logic [15:0]         m_active [NUM_CFG];
    logic [15:0]         m_status [NUM_STAT];
    logic [NUM_STAT-1:0] m_mask;

    asa_cfg_reg_bank #(
        .NUM_CFG   (NUM_CFG),
        .CFG_NBITS (CFG_NBITS),
        .NUM_STAT  (NUM_STAT),
        .ADDR_LSB  (ADDR_LSB),
        .CFG_RST   (CFG_RST)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .clk_div    (clk_div),
        .reg_bs     (reg_bs),
        .reg_rd     (reg_rd),
        .reg_wr     (reg_wr),
        .reg_addr   (reg_addr),
        .reg_din    (reg_din),
        .pio_ack    (pio_ack),
        .pio_rvalid (pio_rvalid),
        .pio_rdata  (pio_rdata),
        .cfg_out    (cfg_out),
        .cfg_update (cfg_update),
        .stat_event (stat_event),
        .stat_irq   (stat_irq)
    );

    always #5 clk = ~clk;

    // Pacing strobe: high in one of every div_n cycles.
    initial begin
        clk_div = 1'b1;
        forever begin
            @(negedge clk);
            div_cnt++;
            clk_div = ((div_cnt % div_n) == 0);
        end
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    function automatic void model_reset();
        logic [63:0] rv;
        rv = CFG_RST;
        for (int i = 0; i < NUM_CFG; i++) begin
            m_shadow[i] = rv[i*16 +: 16];
            m_active[i] = rv[i*16 +: 16];
        end
        for (int j = 0; j < NUM_STAT; j++) m_status[j] = '0;
        m_mask = '0;
    endfunction

    function automatic logic [63:0] model_cfg();
        logic [63:0] v;
        v = '0;
        for (int i = 0; i < NUM_CFG; i++) v[i*16 +: 16] = m_active[i];
        return v;
    endfunction

    function automatic logic model_irq();
        logic r;
        r = 1'b0;
        for (int j = 0; j < NUM_STAT; j++)
            if (STAT_EN && m_mask[j] && (m_status[j] != 16'h0)) r = 1'b1;
        return r;
    endfunction

    function automatic void model_event(input logic [31:0] ev);
        for (int j = 0; j < NUM_STAT; j++)
            if (STAT_EN) m_status[j] = m_status[j] | ev[j*16 +: 16];
    endfunction

    function automatic void model_write(input int idx, input logic [31:0] din);
        logic [15:0] w;
        w = din[15:0];
        if (idx < NUM_CFG) m_shadow[idx] = w;
        else if (idx == IDX_COMMIT) begin
            if (din[0]) for (int i = 0; i < NUM_CFG; i++) m_active[i] = m_shadow[i];
        end else if (STAT_EN && idx >= IDX_STAT && idx < IDX_STAT + NUM_STAT)
            m_status[idx - IDX_STAT] = m_status[idx - IDX_STAT] & ~w;
        else if (STAT_EN && idx == IDX_MASK) m_mask = din[NUM_STAT-1:0];
    endfunction

    function automatic void exp_read(input int idx, output logic mapped, output logic [31:0] d);
        mapped = 1'b0;
        d = '0;
        if (idx < NUM_CFG) begin
            mapped = 1'b1; d = {16'h0, m_shadow[idx]};
        end else if (idx == IDX_COMMIT) begin
            mapped = 1'b1;
        end else if (STAT_EN && idx >= IDX_STAT && idx < IDX_STAT + NUM_STAT) begin
            mapped = 1'b1; d = {16'h0, m_status[idx - IDX_STAT]};
        end else if (STAT_EN && idx == IDX_MASK) begin
            mapped = 1'b1; d = 32'(m_mask);
        end
    endfunction

    // One PIO access with a one-cycle request; checks ack timing, read data, commit and irq.
    task automatic access(input logic wr, input int idx, input logic [31:0] din,
                          input logic [31:0] ev, input logic inj, input logic [31:0] inj_din,
                          input string tag);
        logic        e_map, inj_on, held_bad, got_rv;
        logic [31:0] e_d, got_d;
        logic [63:0] cfg_old, cfg_new, cfg_k1, cfg_k2;
        logic        is_commit;
        logic        divs [0:65];
        int          ack_first, ack_last, upd_cnt, upd_first, d1, d2;

        exp_read(idx, e_map, e_d);
        is_commit = wr && (idx == IDX_COMMIT) && din[0];
        cfg_old = model_cfg();
        for (int k = 0; k <= 65; k++) divs[k] = 1'b0;
        ack_first = 0; ack_last = 0; upd_cnt = 0; upd_first = 0;
        held_bad = 1'b0; got_rv = 1'b0; got_d = '0; inj_on = 1'b0;
        cfg_k1 = '0; cfg_k2 = '0;

        @(negedge clk);
        reg_bs = 1'b1; reg_rd = !wr; reg_wr = wr;
        reg_addr = (32'(idx) << ADDR_LSB) | 32'($urandom_range(0, 3));
        reg_din = din; stat_event = ev;
        @(posedge clk); #1;
        reg_bs = 1'b0; reg_rd = 1'b0; reg_wr = 1'b0; stat_event = '0;
        if (wr) model_write(idx, din);
        model_event(ev);
        cfg_new = model_cfg();

        for (int k = 1; k <= 64; k++) begin
            if (ack_first != 0 && !pio_ack) break;
            if (pio_ack) begin
                if (ack_first == 0) begin
                    ack_first = k; got_rv = pio_rvalid; got_d = pio_rdata;
                    if (inj) begin
                        reg_bs = 1'b1; reg_wr = 1'b1; reg_rd = 1'b0;
                        reg_addr = 32'(idx) << ADDR_LSB; reg_din = inj_din; inj_on = 1'b1;
                    end
                end else if (pio_rvalid !== got_rv || pio_rdata !== got_d) held_bad = 1'b1;
                ack_last = k;
            end
            if (cfg_update) begin
                upd_cnt++;
                if (upd_first == 0) upd_first = k;
            end
            if (k == 1) cfg_k1 = cfg_out;
            if (k == 2) cfg_k2 = cfg_out;
            @(posedge clk);
            divs[k] = clk_div;
            #1;
            if (inj_on) begin
                reg_bs = 1'b0; reg_wr = 1'b0; inj_on = 1'b0;
            end
        end

        d1 = 0; d2 = 0;
        for (int k = 1; k <= 64; k++)
            if (divs[k]) begin
                if (d1 == 0) d1 = k;
                else if (d2 == 0) d2 = k;
            end

        n_tx++;
        $display("tx %0d %s: %s idx=%0d din=0x%08h ev=0x%08h ack@%0d..%0d rvalid=%0b rdata=0x%08h",
                 n_tx, tag, wr ? "WR" : "RD", idx, din, ev, ack_first, ack_last, got_rv, got_d);
        check_val({tag, "/ack_rise"}, 64'(ack_first), 64'(d1 + 1));
        check_val({tag, "/ack_fall"}, 64'(ack_last), 64'(d2));
        check_val({tag, "/ack_hold"}, 64'(held_bad), 64'(0));
        check_val({tag, "/rvalid"}, 64'(got_rv), 64'(!wr && e_map));
        if (!wr) check_val({tag, "/rdata"}, 64'(got_d), 64'(e_d));
        check_val({tag, "/cfg_t1"}, cfg_k1, cfg_old);
        check_val({tag, "/cfg_t2"}, cfg_k2, cfg_new);
        check_val({tag, "/upd_cnt"}, 64'(upd_cnt), 64'(is_commit));
        if (is_commit) check_val({tag, "/upd_at"}, 64'(upd_first), 64'(2));
        check_val({tag, "/irq"}, 64'(stat_irq), 64'(model_irq()));
    endtask

    task automatic pulse_event(input logic [31:0] ev, input string tag);
        logic irq_before;
        @(posedge clk); #1;
        irq_before = model_irq();
        stat_event = ev;
        @(posedge clk); #1;
        stat_event = '0;
        model_event(ev);
        check_val({tag, "/irq_t1"}, 64'(stat_irq), 64'(irq_before));
        @(posedge clk); #1;
        check_val({tag, "/irq_t2"}, 64'(stat_irq), 64'(model_irq()));
    endtask

    initial begin
        int ack_seen;
        rst = 1'b1; reg_bs = 1'b0; reg_rd = 1'b0; reg_wr = 1'b0;
        reg_addr = '0; reg_din = '0; stat_event = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_val("rst/ack", 64'(pio_ack), 64'(0));
        check_val("rst/rvalid", 64'(pio_rvalid), 64'(0));
        check_val("rst/rdata", 64'(pio_rdata), 64'(0));
        check_val("rst/cfg_out", cfg_out, CFG_RST);
        check_val("rst/update", 64'(cfg_update), 64'(0));
        check_val("rst/irq", 64'(stat_irq), 64'(0));
        rst = 1'b0;

        access(1'b0, 1, 32'h0, 32'h0, 1'b0, 32'h0, "rst_word1");
        access(1'b1, 0, 32'h0000_1234, 32'h0, 1'b0, 32'h0, "shadow_wr");
        access(1'b0, 0, 32'h0, 32'h0, 1'b0, 32'h0, "shadow_rd");
        access(1'b1, IDX_COMMIT, 32'h1, 32'h0, 1'b0, 32'h0, "commit");
        access(1'b1, IDX_COMMIT, 32'h0, 32'h0, 1'b0, 32'h0, "commit_off");
        access(1'b1, IDX_COMMIT, 32'h1, 32'h0, 1'b0, 32'h0, "commit_rep");
        access(1'b0, IDX_COMMIT, 32'h0, 32'h0, 1'b0, 32'h0, "commit_rd");

        div_n = 4;
        access(1'b1, 3, 32'h0000_AAAA, 32'h0, 1'b1, 32'h0000_BBBB, "ack_ignore");
        access(1'b0, 3, 32'h0, 32'h0, 1'b0, 32'h0, "ack_ignore_rd");
        div_n = 1;

        access(1'b1, IDX_MASK, 32'h1, 32'h0, 1'b0, 32'h0, "mask_wr");
        pulse_event(32'h0000_0008, "ev_bit3");
        access(1'b0, IDX_STAT, 32'h0, 32'h0, 1'b0, 32'h0, "stat_rd");
        access(1'b1, IDX_STAT, 32'h0000_0008, 32'h0000_0008, 1'b0, 32'h0, "w1c_collide");
        access(1'b0, IDX_STAT, 32'h0, 32'h0, 1'b0, 32'h0, "collide_rd");
        access(1'b1, IDX_STAT, 32'h0000_0008, 32'h0, 1'b0, 32'h0, "w1c_clear");
        access(1'b0, IDX_STAT, 32'h0, 32'h0001_0040, 1'b0, 32'h0, "stat_rd_at_t");
        access(1'b0, IDX_STAT + 1, 32'h0, 32'h0, 1'b0, 32'h0, "stat_rd_late");
        access(1'b0, 15, 32'h0, 32'h0, 1'b0, 32'h0, "unmapped_rd");
        access(1'b1, 2, 32'hFFFF_5555, 32'h0, 1'b0, 32'h0, "trunc_wr");
        access(1'b0, 2, 32'h0, 32'h0, 1'b0, 32'h0, "trunc_rd");
        pulse_event(32'hFFFF_FFFF, "ev_ones");
        access(1'b0, IDX_STAT, 32'h0, 32'h0, 1'b0, 32'h0, "ones_rd");

        for (int n = 0; n < 200; n++) begin
            int op, idx;
            logic [31:0] din, ev;
            div_n = $urandom_range(1, 4);
            op  = $urandom_range(0, 9);
            din = $urandom;
            ev  = ($urandom_range(0, 3) == 0) ? ($urandom & $urandom & $urandom) : 32'h0;
            case (op)
                0, 1, 2: access(1'b1, $urandom_range(0, NUM_CFG - 1), din, ev, 1'b0, 32'h0, "rnd_cfg_wr");
                3, 4:    access(1'b0, $urandom_range(0, 15), din, ev, 1'b0, 32'h0, "rnd_rd");
                5:       access(1'b1, IDX_COMMIT, din, ev, 1'b0, 32'h0, "rnd_commit");
                6:       access(1'b1, $urandom_range(IDX_STAT, IDX_STAT + NUM_STAT - 1), din, ev, 1'b0, 32'h0, "rnd_w1c");
                7:       access(1'b1, IDX_MASK, din, ev, 1'b0, 32'h0, "rnd_mask");
                default: begin
                    idx = $urandom_range(0, 15);
                    access(1'b1, idx, din, ev, 1'b0, 32'h0, "rnd_any_wr");
                end
            endcase
        end

        // Reset while an access waits for the pacing strobe: no ack may follow.
        div_n = 8;
        @(negedge clk);
        reg_bs = 1'b1; reg_wr = 1'b1; reg_addr = 32'h0; reg_din = 32'h0000_BEEF;
        @(posedge clk); #1;
        reg_bs = 1'b0; reg_wr = 1'b0; rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        ack_seen = 0;
        for (int k = 0; k < 20; k++) begin
            if (pio_ack) ack_seen++;
            @(posedge clk); #1;
        end
        check_val("midrst/no_ack", 64'(ack_seen), 64'(0));
        check_val("midrst/cfg_out", cfg_out, CFG_RST);
        access(1'b0, 0, 32'h0, 32'h0, 1'b0, 32'h0, "midrst_rd");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
